// File: rtl/mult_share_pkg.sv
// Package for the shared-multiplier controller.
//   - FSM state encoding (legacy-compatible 2-bit localparams)
//   - operand / product widths
//   - round-robin "next granted index" search used by mult_rr_arbiter
package mult_share_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_RSP  = 2'd2;

  localparam int OPW = 8;   // operand width
  localparam int PW  = 16;  // product width

  // The search function works on a fixed 16-entry view so it can serve any
  // legal NREQ (2..16); callers zero-extend their request vector.
  localparam int RR_MAXN = 16;
  localparam int RR_IDXW = 4;

  // First set bit of valid[nreq-1:0], searching upward from ptr with
  // wrap-around. Returns 0 when nothing is set; the caller qualifies the
  // result with its own "any valid" term.
  function automatic logic [RR_IDXW-1:0] rr_next_idx(
    input logic [RR_MAXN-1:0] valid,
    input logic [RR_IDXW-1:0] ptr,
    input int                 nreq
  );
    logic [RR_IDXW-1:0] pick;
    logic               found;
    int                 idx;
    pick  = '0;
    found = 1'b0;
    for (int off = 0; off < RR_MAXN; off++) begin
      idx = (int'(ptr) + off) % nreq;
      if (!found && (off < nreq) && valid[idx[RR_IDXW-1:0]]) begin
        pick  = idx[RR_IDXW-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mult_rr_arbiter.sv
// Round-robin arbiter: picks the first valid requester at or above rr_ptr
// (wrapping), only while enable is high.
// Ports:
//   req_valid  in   NREQ  request vector
//   rr_ptr     in   IDW   highest-priority index this cycle
//   enable     in   1     grant permitted (controller is idle)
//   grant      out  NREQ  one-hot grant or zero
//   gnt_idx    out  IDW   encoded grant index (meaningful when gnt_valid)
//   gnt_valid  out  1     a grant is issued this cycle
module mult_rr_arbiter
  import mult_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  rr_ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_valid
);

  logic [RR_MAXN-1:0] valid_ext;
  logic [RR_IDXW-1:0] pick;

  always_comb begin
    valid_ext              = '0;
    valid_ext[NREQ-1:0]    = req_valid;
    pick                   = rr_next_idx(valid_ext, RR_IDXW'(rr_ptr), NREQ);
    gnt_valid              = enable && (|req_valid);
    gnt_idx                = pick[IDW-1:0];
    grant                  = '0;
    if (gnt_valid) grant[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/parallel_unsigned_mult.sv
// Combinational 8x8 -> 16 unsigned multiplier. The partial products are
// summed in one expression so synthesis is free to build the carry-save
// (Wallace) reduction tree.
// Ports:
//   a, b  in   OPW  unsigned operands
//   p     out  PW   exact product a*b
module parallel_unsigned_mult
  import mult_share_pkg::*;
(
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic [PW-1:0]  p
);

  always_comb begin
    p = '0;
    for (int i = 0; i < OPW; i++) begin
      if (b[i]) p = p + (PW'(a) << i);
    end
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one parallel_unsigned_mult among NREQ requesters. Round-robin
// arbitration, registered operand capture, one operation in flight, and a
// single tagged response channel.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req_valid    in   NREQ      per-requester request valid
//   req_ready    out  NREQ      per-requester accept (one-hot or zero, idle only)
//   req_a/req_b  in   NREQ*8    operands, requester i at [8i+7:8i]
//   rsp_valid    out  1         response valid, held until rsp_ready
//   rsp_ready    in   1         response accept
//   rsp_id       out  IDW       owning requester index
//   rsp_p        out  16        product
// Build option: MULT_ZERO_SKIP_EN -- a zero operand bypasses the MUL state and
// the response is presented one cycle after accept.
module mult_share_ctrl
  import mult_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*OPW-1:0] req_a,
  input  logic [NREQ*OPW-1:0] req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [PW-1:0]       rsp_p
);

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [OPW-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [IDW-1:0] op_id_q, op_id_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [PW-1:0]  rsp_p_q, rsp_p_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_valid;
  logic [OPW-1:0]  sel_a, sel_b;
  logic [PW-1:0]   mul_p;

  mult_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .enable    (state_q == ST_IDLE),
    .grant     (grant),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // The FSM already sits in IDLE during reset, so the grant must also be
  // gated by rst_n to keep req_ready low while reset is held.
  assign req_ready = grant & {NREQ{rst_n}};

  // Fed only from the captured operands, so its inputs move only on accept.
  parallel_unsigned_mult u_mult (
    .a (op_a_q),
    .b (op_b_q),
    .p (mul_p)
  );

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*OPW +: OPW];
        sel_b = req_b[i*OPW +: OPW];
      end
    end
  end

  always_comb begin
    // NOTE: every _d starts from its _q so no path leaves a signal unassigned;
    // that is what keeps this block free of inferred latches.
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_id_d     = op_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_p_d     = rsp_p_q;
    rsp_id_d    = rsp_id_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          op_a_d   = sel_a;
          op_b_d   = sel_b;
          op_id_d  = gnt_idx;
          rr_ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
          state_d  = ST_MUL;
`ifdef MULT_ZERO_SKIP_EN
          if ((sel_a == '0) || (sel_b == '0)) begin
            rsp_p_d     = '0;
            rsp_id_d    = gnt_idx;
            rsp_valid_d = 1'b1;
            state_d     = ST_RSP;
          end
`endif
        end
      end
      ST_MUL: begin
        rsp_p_d     = mul_p;
        rsp_id_d    = op_id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_p_q     <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_id_q     <= op_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_p_q     <= rsp_p_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_p     = rsp_p_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Self-checking bench for mult_share_ctrl (NREQ=4). A transaction-level model
// (busy flag, cycles since grant, round-robin pointer, expected product) is
// compared with the DUT every cycle; directed scenarios add literal checks.
`timescale 1ns/1ps
module tb_mult_share_ctrl;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*8-1:0] req_a, req_b;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [15:0]   rsp_p;

  mult_share_ctrl #(.NREQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit          m_busy;
  int          m_age;    // cycles since the grant cycle
  int          m_ptr;
  int          m_id;
  bit          m_zero;
  int unsigned m_p;
  int          last_g;   // grant taken at the most recent edge, -1 if none

  function automatic void m_reset();
    m_busy = 0; m_age = 0; m_ptr = 0; m_id = 0; m_zero = 0; m_p = 0;
  endfunction

  function automatic int m_lat();
`ifdef MULT_ZERO_SKIP_EN
    if (m_zero) return 1;
`endif
    return 2;
  endfunction

  function automatic int m_pick();
    int idx;
    if (m_busy || !rst_n) return -1;
    for (int off = 0; off < N; off++) begin
      idx = (m_ptr + off) % N;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic bit m_rsp_valid();
    return m_busy && (m_age >= m_lat());
  endfunction

  function automatic void m_edge();
    int g;
    int unsigned a, b;
    g = m_pick();
    last_g = g;
    if (!rst_n) begin
      m_reset();
      last_g = -1;
    end else if (m_busy) begin
      if (m_rsp_valid() && rsp_ready) m_busy = 0;
      else m_age++;
    end else if (g >= 0) begin
      a      = req_a[g*8 +: 8];
      b      = req_b[g*8 +: 8];
      m_busy = 1;
      m_age  = 1;
      m_id   = g;
      m_p    = a * b;
      m_zero = (a == 0) || (b == 0);
      m_ptr  = (g + 1) % N;
    end
  endfunction

  // Compare combinational and registered outputs against the model.
  task automatic settle();
    logic [N-1:0] exp_rdy;
    int g;
    #1;
    g = m_pick();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    check("rsp_valid", rsp_valid, m_rsp_valid());
    if (m_rsp_valid()) begin
      check("rsp_p", rsp_p, m_p[15:0]);
      check("rsp_id", rsp_id, m_id);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  // Run until every asserted request has been accepted, dropping each one
  // right after its accept edge.
  task automatic retire();
    for (int k = 0; k < 200 && req_valid != '0; k++) begin
      settle();
      tick();
      if (last_g >= 0) req_valid[last_g] = 1'b0;
    end
    if (req_valid != '0) bound_fail("retire");
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int k = 0; k < 20 && m_busy; k++) begin
      settle();
      tick();
    end
    if (m_busy) bound_fail("drain");
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
    req_valid[i]    = 1'b1;
  endtask

  // ---------------- requester protocol monitor ----------------
  logic [N-1:0]   p_valid, p_ready;
  logic [N*8-1:0] p_a, p_b;
  logic           p_rst = 1'b0;
  always @(posedge clk) begin
    if (rst_n && p_rst) begin
      for (int i = 0; i < N; i++) begin
        if (p_valid[i] && !p_ready[i] &&
            (!req_valid[i] || req_a[i*8 +: 8] !== p_a[i*8 +: 8] ||
             req_b[i*8 +: 8] !== p_b[i*8 +: 8]))
          $error("requester %0d dropped or changed a pending request", i);
      end
    end
    p_valid <= req_valid;
    p_ready <= req_ready;
    p_a     <= req_a;
    p_b     <= req_b;
    p_rst   <= rst_n;
  end

  // ---------------- stimulus ----------------
  int g_idx[$];
  int g_cyc[$];

  initial begin
    m_reset();
    last_g    = -1;
    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    // Reset state, with requests present to show req_ready is held low.
    check("rst_req_ready", req_ready, 4'b0000);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_p", rsp_p, 16'h0000);
    check("rst_rsp_id", rsp_id, 2'd0);
    req_valid = '0;
    rst_n     = 1'b1;

    // T3 fairness: all four valid continuously.
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 8'(i + 1), 8'h10);
    for (int c = 0; c < 25; c++) begin
      settle();
      for (int i = 0; i < N; i++)
        if (req_ready[i]) begin g_idx.push_back(i); g_cyc.push_back(c); end
      if (rsp_valid) check("T3_product", rsp_p, (32'(rsp_id) + 1) * 32'h10);
      tick();
    end
    check("T3_grant_count_ok", g_idx.size() >= 8, 1'b1);
    for (int k = 0; k < 8 && k < g_idx.size(); k++) begin
      check("T3_grant_order", g_idx[k], k % 4);
      if (k > 0) check("T3_spacing", g_cyc[k] - g_cyc[k-1], 3);
    end
    retire();
    drain();

    // T1 single request.
    set_req(0, 8'h0F, 8'h11);
    settle();
    check("T1_ready", req_ready, 4'b0001);
    tick();
    req_valid[0] = 1'b0;
    settle();
    check("T1_no_rsp_in_mul", rsp_valid, 1'b0);
    tick();
    settle();
    check("T1_rsp_valid", rsp_valid, 1'b1);
    check("T1_rsp_p", rsp_p, 16'h00FF);
    check("T1_rsp_id", rsp_id, 2'd0);
    tick();
    drain();

    // T2 maximum operands.
    set_req(2, 8'hFF, 8'hFF);
    settle();
    check("T2_ready", req_ready, 4'b0100);
    tick();
    req_valid[2] = 1'b0;
    settle();
    tick();
    settle();
    check("T2_rsp_p", rsp_p, 16'hFE01);
    check("T2_rsp_id", rsp_id, 2'd2);
    tick();
    drain();

    // T4 back-pressure.
    rsp_ready = 1'b0;
    set_req(3, 8'h03, 8'h05);
    settle();
    check("T4_grant", req_ready, 4'b1000);
    tick();
    req_valid[3] = 1'b0;
    settle();
    tick();
    set_req(0, 8'h02, 8'h02);
    for (int c = 0; c < 5; c++) begin
      settle();
      check("T4_hold_valid", rsp_valid, 1'b1);
      check("T4_hold_p", rsp_p, 16'h000F);
      check("T4_hold_id", rsp_id, 2'd3);
      check("T4_ready_zero", req_ready, 4'b0000);
      tick();
    end
    rsp_ready = 1'b1;
    settle();
    tick();
    settle();
    check("T4_next_grant", req_ready, 4'b0001);
    tick();
    req_valid[0] = 1'b0;
    drain();

    // T5 zero operand.
    set_req(1, 8'h00, 8'h37);
    settle();
    check("T5_ready", req_ready, 4'b0010);
    tick();
    req_valid[1] = 1'b0;
    settle();
`ifdef MULT_ZERO_SKIP_EN
    check("T5_rsp_valid_1cyc", rsp_valid, 1'b1);
    check("T5_rsp_p", rsp_p, 16'h0000);
`else
    check("T5_no_rsp_1cyc", rsp_valid, 1'b0);
    tick();
    settle();
    check("T5_rsp_valid_2cyc", rsp_valid, 1'b1);
    check("T5_rsp_p", rsp_p, 16'h0000);
`endif
    tick();
    drain();

    // Randomized traffic with random back-pressure.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom % 4 == 0)) begin
          logic [7:0] a, b;
          case ($urandom % 8)
            0:       a = 8'h00;
            1:       a = 8'hFF;
            default: a = 8'($urandom);
          endcase
          case ($urandom % 8)
            0:       b = 8'h00;
            1:       b = 8'hFF;
            default: b = 8'($urandom);
          endcase
          set_req(i, a, b);
        end
      end
      rsp_ready = ($urandom % 10) < 7;
      settle();
      tick();
      if (last_g >= 0) req_valid[last_g] = 1'b0;
    end
    rsp_ready = 1'b1;
    retire();
    drain();

    // T6 reset during MUL.
    set_req(0, 8'h07, 8'h09);
    settle();
    tick();
    req_valid[0] = 1'b0;
    settle();
    set_req(0, 8'h02, 8'h03);
    set_req(1, 8'h04, 8'h05);
    rst_n = 1'b0;
    m_reset();
    #1;
    check("T6_rsp_valid_async", rsp_valid, 1'b0);
    check("T6_ready_in_reset", req_ready, 4'b0000);
    tick();
    rst_n = 1'b1;
    settle();
    check("T6_first_grant", req_ready, 4'b0001);
    retire();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time guard.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
